multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore-FSM control unit for the multi-cycle MIPS datapath; successor to the single-cycle combinational Control decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB steps and drives per-step datapath enables. Memory accesses use a ready handshake guarded by a watchdog. The block sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before error; 0 = wait forever
TMO_W, 5, width of watchdog counter; must hold MEM_TIMEOUT
ALUCTR_W, 2, width of ALUctr; values above 2 bits are zero-extended

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  opcode from instruction register (IR[31:26])
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if zero
IorD  out  1  0=PC addresses memory, 1=ALUOut
IRWrite  out  1  load instruction register
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  register write data from MDR
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
ALUctr  out  ALUCTR_W  00=add, 01=sub, 10=funct-decoded, 11=lui
state  out  4  current state encoding, for debug
mem_err  out  1  sticky memory timeout flag

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, LUIEX=9, LUIWB=10, JUMP=11, ERR=12.
- reset high at an edge: state<=FETCH, watchdog<=0, mem_err<=0. While reset is high, all outputs are forced to 0 (state output reads 0).
- Outputs are a pure function of the state register; no Mealy paths except PCWrite/IRWrite gating by mem_ready.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=add, PCSource=00. IRWrite and PCWrite assert only when mem_ready=1. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUctr=add. Transitions by op: 000000->EXEC; 100011/101011->MEMADR; 000100->BRANCH; 001111->LUIEX; 000010->JUMP (only with the macro, see Optional Feature); any other op->FETCH (treated as NOP).
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state is MEMRD for lw (100011) and MEMWR for sw (101011).
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUctr=10. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01. Next state FETCH.
- LUIEX: ALUSrcA=1, ALUSrcB=10, ALUctr=11. Next state LUIWB.
- LUIWB: RegWrite=1, RegDst=0. Next state FETCH.
- Cycle counts (mem_ready constantly high): R-type 4, lw 5, sw 4, beq 3, lui 4.
- Watchdog:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0. Clears on mem_ready=1 and on any state change.
  - If MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT: next state ERR and mem_err<=1.
  - ERR drives all enables 0, holds until reset, and mem_err stays 1.
  - mem_ready=1 in the same cycle the count reaches the limit: the handshake wins and no error is raised.
- op is sampled only in DECODE and MEMADR; changes in other states are ignored.

Optional Feature:
MC_JUMP_EN: when defined, DECODE with op=000010 goes to JUMP, which drives PCWrite=1, PCSource=10, then goes to FETCH (j = 3 cycles). When undefined, the JUMP state is not generated and op=000010 takes the NOP path DECODE->FETCH.

Test Plan:
- reset=1 for 2 cycles, then op=000000, mem_ready=1 -> outputs all 0 during reset; state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
- op=100011, mem_ready held 0 for 3 cycles in MEMRD, MEM_TIMEOUT=16 -> state stays 3 for 3 cycles, then goes to 4 with MemtoReg=1 and RegWrite=1; mem_err stays 0.
- op=000100, zero=1 -> sequence 0,1,8,0; PCWriteCond=1 and PCSource=01 in state 8; ALUctr=01.
- op=001111 -> sequence 0,1,9,10,0; ALUctr=11 in state 9; RegWrite=1 and RegDst=0 in state 10.
- mem_ready=0 constantly in FETCH, MEM_TIMEOUT=16 -> after 16 cycles state=12 and mem_err=1, held until reset; reset clears both.
- op=000010 -> with MC_JUMP_EN: sequence 0,1,11,0 with PCSource=10. Without it: sequence 0,1,0.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath, with a memory-ready watchdog.
// Optional jump support is compiled in when MC_JUMP_EN is defined.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5,
   parameter int ALUCTR_W    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          op,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                IorD,
   output logic                IRWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                MemtoReg,
   output logic                RegDst,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          PCSource,
   output logic [ALUCTR_W-1:0] ALUctr,
   output logic [3:0]          state,
   output logic                mem_err
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_LUIEX  = 4'd9,
      S_LUIWB  = 4'd10,
`ifdef MC_JUMP_EN
      S_JUMP   = 4'd11,
`endif
      S_ERR    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
`ifdef MC_JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif
   localparam logic [TMO_W:0] TMO_LIM = (TMO_W+1)'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [TMO_W-1:0] wdog_q, wdog_d;
   logic             mem_err_q, mem_err_d;
   logic             waiting;
   logic [TMO_W:0]   wdog_inc;

   // The branch decision (PCWriteCond & zero) is made in the datapath.
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         wdog_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wdog_q    <= wdog_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wdog_d    = '0;
      mem_err_d = mem_err_q;
      waiting   = 1'b0;
      wdog_inc  = {1'b0, wdog_q} + 1'b1;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE; else waiting = 1'b1;
         S_DECODE: begin
            case (op)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_LUI:       state_d = S_LUIEX;
`ifdef MC_JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else waiting = 1'b1;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH; else waiting = 1'b1;
         S_EXEC:   state_d = S_ALUWB;
         S_LUIEX:  state_d = S_LUIWB;
         S_ERR:    state_d = S_ERR;
         default:  state_d = S_FETCH;
      endcase
      // Counter only advances while stalled in place; any ready or move clears it.
      if (waiting) begin
         wdog_d = wdog_inc[TMO_W-1:0];
         if (MEM_TIMEOUT != 0 && wdog_inc == TMO_LIM) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
            wdog_d    = '0;
         end
      end
   end

   logic       pc_write_c, pc_write_cond_c, iord_c, ir_write_c, mem_read_c;
   logic       mem_write_c, memtoreg_c, regdst_c, reg_write_c, alu_src_a_c;
   logic [1:0] alu_src_b_c, pc_source_c, alu_ctr_c;

   always_comb begin
      pc_write_c      = 1'b0;
      pc_write_cond_c = 1'b0;
      iord_c          = 1'b0;
      ir_write_c      = 1'b0;
      mem_read_c      = 1'b0;
      mem_write_c     = 1'b0;
      memtoreg_c      = 1'b0;
      regdst_c        = 1'b0;
      reg_write_c     = 1'b0;
      alu_src_a_c     = 1'b0;
      alu_src_b_c     = 2'b00;
      pc_source_c     = 2'b00;
      alu_ctr_c       = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_read_c  = 1'b1;
            alu_src_b_c = 2'b01;
            ir_write_c  = mem_ready;
            pc_write_c  = mem_ready;
         end
         S_DECODE: alu_src_b_c = 2'b11;
         S_MEMADR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
         end
         S_MEMRD: begin
            mem_read_c = 1'b1;
            iord_c     = 1'b1;
         end
         S_MEMWB: begin
            reg_write_c = 1'b1;
            memtoreg_c  = 1'b1;
         end
         S_MEMWR: begin
            mem_write_c = 1'b1;
            iord_c      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a_c = 1'b1;
            alu_ctr_c   = 2'b10;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            regdst_c    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_c     = 1'b1;
            alu_ctr_c       = 2'b01;
            pc_write_cond_c = 1'b1;
            pc_source_c     = 2'b01;
         end
         S_LUIEX: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
            alu_ctr_c   = 2'b11;
         end
         S_LUIWB: reg_write_c = 1'b1;
`ifdef MC_JUMP_EN
         S_JUMP: begin
            pc_write_c  = 1'b1;
            pc_source_c = 2'b10;
         end
`endif
         default: ;
      endcase
   end

   // Reset masks every output combinationally, not just from the next edge.
   assign PCWrite     = !reset && pc_write_c;
   assign PCWriteCond = !reset && pc_write_cond_c;
   assign IorD        = !reset && iord_c;
   assign IRWrite     = !reset && ir_write_c;
   assign MemRead     = !reset && mem_read_c;
   assign MemWrite    = !reset && mem_write_c;
   assign MemtoReg    = !reset && memtoreg_c;
   assign RegDst      = !reset && regdst_c;
   assign RegWrite    = !reset && reg_write_c;
   assign ALUSrcA     = !reset && alu_src_a_c;
   assign ALUSrcB     = reset ? 2'b00 : alu_src_b_c;
   assign PCSource    = reset ? 2'b00 : pc_source_c;
   assign ALUctr      = reset ? '0 : ALUCTR_W'(alu_ctr_c);
   assign state       = reset ? 4'd0 : state_q;
   assign mem_err     = !reset && mem_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: expected per-cycle state/control
// sequences are built from instruction class and stall counts.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource, ALUctr;
   logic [3:0] state;
   logic       mem_err;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(16), .TMO_W(5), .ALUCTR_W(2)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUctr(ALUctr), .state(state), .mem_err(mem_err)
   );

   logic [15:0] ctrl_obs;
   assign ctrl_obs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUctr};

   // Control word each step should present, straight from the step descriptions.
   function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
      logic pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, sa;
      logic [1:0] sb, ps, ac;
      {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, sa} = '0;
      sb = 2'b00; ps = 2'b00; ac = 2'b00;
      case (st)
         4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         4'd1:  sb = 2'b11;
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  begin mrd = 1; iord = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mwr = 1; iord = 1; end
         4'd6:  begin sa = 1; ac = 2'b10; end
         4'd7:  begin rw = 1; rdst = 1; end
         4'd8:  begin sa = 1; ac = 2'b01; pcwc = 1; ps = 2'b01; end
         4'd9:  begin sa = 1; sb = 2'b10; ac = 2'b11; end
         4'd10: rw = 1;
         4'd11: begin pcw = 1; ps = 2'b10; end
         default: ;
      endcase
      return {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, sa, sb, ps, ac};
   endfunction

   task automatic check3(input string tag, input logic [3:0] st, input logic [15:0] ctl,
                         input logic err);
      ncmp++;
      assert (state === st) else begin
         nerr++; $error("FAIL %s state: got %0d want %0d", tag, state, st);
      end
      ncmp++;
      assert (ctrl_obs === ctl) else begin
         nerr++; $error("FAIL %s ctrl(st=%0d): got %h want %h", tag, st, ctrl_obs, ctl);
      end
      ncmp++;
      assert (mem_err === err) else begin
         nerr++; $error("FAIL %s mem_err: got %b want %b", tag, mem_err, err);
      end
   endtask

   // Called at a negedge: drive inputs, check, advance one clock.
   task automatic chk_step(input string tag, input logic [3:0] st, input logic mr,
                           input logic [5:0] o, input logic err);
      reset = 1'b0; mem_ready = mr; op = o; zero = 1'($urandom);
      #1 check3(tag, st, exp_ctrl(st, mr), err);
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      reset = 1'b1; mem_ready = 1'($urandom); op = 6'($urandom); zero = 1'($urandom);
      #1 check3(tag, 4'd0, 16'h0000, 1'b0);
      @(negedge clk);
   endtask

   typedef struct { logic [3:0] st; logic mr; } step_t;

   // Expected path of one instruction from FETCH back to (not including) FETCH.
   task automatic run_instr(input string tag, input logic [5:0] opc, input int sf,
                            input int sm);
      step_t q[$];
      for (int i = 0; i < sf; i++) q.push_back('{4'd0, 1'b0});
      q.push_back('{4'd0, 1'b1});
      q.push_back('{4'd1, 1'($urandom)});
      case (opc)
         6'b000000: begin q.push_back('{4'd6, 1'($urandom)}); q.push_back('{4'd7, 1'($urandom)}); end
         6'b100011: begin
            q.push_back('{4'd2, 1'($urandom)});
            for (int i = 0; i < sm; i++) q.push_back('{4'd3, 1'b0});
            q.push_back('{4'd3, 1'b1});
            q.push_back('{4'd4, 1'($urandom)});
         end
         6'b101011: begin
            q.push_back('{4'd2, 1'($urandom)});
            for (int i = 0; i < sm; i++) q.push_back('{4'd5, 1'b0});
            q.push_back('{4'd5, 1'b1});
         end
         6'b000100: q.push_back('{4'd8, 1'($urandom)});
         6'b001111: begin q.push_back('{4'd9, 1'($urandom)}); q.push_back('{4'd10, 1'($urandom)}); end
`ifdef MC_JUMP_EN
         6'b000010: q.push_back('{4'd11, 1'($urandom)});
`endif
         default: ;
      endcase
      foreach (q[i]) begin
         logic [5:0] o;
         o = (q[i].st == 4'd1 || q[i].st == 4'd2) ? opc : 6'($urandom);
         chk_step(tag, q[i].st, q[i].mr, o, 1'b0);
      end
   endtask

   int sf, sm;
   logic [5:0] rop;
   logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000010};

   initial begin
      @(negedge clk);
      chk_reset("reset0");
      chk_reset("reset1");
      run_instr("rtype", 6'b000000, 0, 0);
      run_instr("lw_stall3", 6'b100011, 0, 3);
      run_instr("beq", 6'b000100, 0, 0);
      run_instr("lui", 6'b001111, 0, 0);
      run_instr("jump", 6'b000010, 0, 0);
      run_instr("sw_stall2", 6'b101011, 2, 2);
      run_instr("nop", 6'b111111, 1, 0);
      run_instr("lw_edge15", 6'b100011, 15, 15);
      run_instr("sw_edge15", 6'b101011, 0, 15);

      for (int n = 0; n < 80; n++) begin
         rop = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
         sf = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
         sm = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
         run_instr("rand", rop, sf, sm);
      end

      // Fetch timeout: 16 stalled cycles, then stuck in ERR until reset.
      for (int i = 0; i < 16; i++) chk_step("fetch_wait", 4'd0, 1'b0, 6'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) chk_step("fetch_err", 4'd12, 1'($urandom), 6'($urandom), 1'b1);
      chk_reset("err_reset");
      chk_step("post_reset", 4'd0, 1'b1, 6'($urandom), 1'b0);

      // Read timeout inside MEMRD.
      chk_step("lw_tmo_dec", 4'd1, 1'b1, 6'b100011, 1'b0);
      chk_step("lw_tmo_adr", 4'd2, 1'b1, 6'b100011, 1'b0);
      for (int i = 0; i < 16; i++) chk_step("memrd_wait", 4'd3, 1'b0, 6'($urandom), 1'b0);
      chk_step("memrd_err", 4'd12, 1'b1, 6'($urandom), 1'b1);
      chk_reset("err_reset2");
      run_instr("rtype_final", 6'b000000, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
